mesh_sort_ctrl: RTL and testbench

//   Global shearsort sequencer for the PE mesh. One instance sits upstream of the PE array.
//   On start it drives a load strobe, then SQRT_N odd-even transposition steps per phase.

---
 rtl/mesh_sort_ctrl_pkg.sv | 18 +
 rtl/mesh_sort_ctrl_step_counter.sv | 57 +++++
 rtl/mesh_sort_ctrl.sv | 119 +++++++++++
 tb/tb_mesh_sort_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_sort_ctrl_pkg.sv
// Shared definitions for the shearsort sequencer and the PE compare-exchange logic.
package mesh_sort_ctrl_pkg;

  // Sequencer states; the encodings are also decoded by the PE array.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SORT   = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Shearsort needs log2(side) row+column phase pairs plus a final row phase.
  function automatic int num_phases(input int log_sqrt_n);
    return 2 * log_sqrt_n + 1;
  endfunction

endpackage

// File: rtl/mesh_sort_ctrl_step_counter.sv
// Nested step/phase counter: step wraps every SQRT_N cycles and bumps the phase.
module mesh_sort_ctrl_step_counter #(
  parameter int SQRT_N     = 8,
  parameter int LOG_SQRT_N = 3,
  parameter int NUM_PHASES = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [LOG_SQRT_N-1:0] step_o,
  output logic [LOG_SQRT_N:0]   phase_o,
  output logic                  last_step_o,
  output logic                  last_phase_o
);

  localparam int PHASE_W = LOG_SQRT_N + 1;
  localparam logic [LOG_SQRT_N-1:0] LAST_STEP  = LOG_SQRT_N'(SQRT_N - 1);
  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  logic [LOG_SQRT_N-1:0] step_q, step_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;

  assign last_step_o  = (step_q == LAST_STEP);
  assign last_phase_o = (phase_q == LAST_PHASE);
  assign step_o       = step_q;
  assign phase_o      = phase_q;

  // Clear wins over count; the phase only advances when the step wraps.
  always_comb begin
    step_d  = step_q;
    phase_d = phase_q;
    if (clr_i) begin
      step_d  = '0;
      phase_d = '0;
    end else if (en_i) begin
      if (last_step_o) begin
        step_d  = '0;
        phase_d = last_phase_o ? '0 : phase_q + 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // Counter registers, cleared asynchronously so a reset mid-pass leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= '0;
      phase_q <= '0;
    end else begin
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/mesh_sort_ctrl.sv
// Global shearsort sequencer: load strobe, NUM_PHASES x SQRT_N sort steps, commit, done.
module mesh_sort_ctrl
  import mesh_sort_ctrl_pkg::*;
#(
  parameter int N          = 64,
  parameter int SQRT_N     = 8,
  parameter int LOG_SQRT_N = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  load_en,
  output logic                  sort_en,
  output logic                  phase_col,
  output logic                  step_odd,
  output logic [LOG_SQRT_N-1:0] step_idx,
  output logic [LOG_SQRT_N:0]   phase_idx,
  output logic                  commit_en,
  output logic                  done
);

  localparam int NUM_PHASES = num_phases(LOG_SQRT_N);

  state_e state_q, state_d;

  logic load_en_q, load_en_d;
  logic sort_en_q, sort_en_d;
  logic commit_en_q, commit_en_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic cnt_clr, cnt_en;
  logic last_step, last_phase;
  logic [LOG_SQRT_N-1:0] step_q;
  logic [LOG_SQRT_N:0]   phase_q;

  // The counter runs only while in SORT and is cleared whenever the next state is not SORT,
  // so it sits at zero on entry and returns to zero on completion or abort.
  mesh_sort_ctrl_step_counter #(
    .SQRT_N    (SQRT_N),
    .LOG_SQRT_N(LOG_SQRT_N),
    .NUM_PHASES(NUM_PHASES)
  ) u_step_counter (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .step_o      (step_q),
    .phase_o     (phase_q),
    .last_step_o (last_step),
    .last_phase_o(last_phase)
  );

  // Next-state and next-output logic; abort overrides every transition outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_SORT;
      S_SORT:   if (last_step && last_phase) state_d = S_COMMIT;
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end

    cnt_en      = (state_q == S_SORT);
    cnt_clr     = (state_d != S_SORT);

    load_en_d   = (state_d == S_LOAD);
    sort_en_d   = (state_d == S_SORT);
    commit_en_d = (state_d == S_COMMIT);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output strobes are registered together so every output is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_en_q   <= 1'b0;
      sort_en_q   <= 1'b0;
      commit_en_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_en_q   <= load_en_d;
      sort_en_q   <= sort_en_d;
      commit_en_q <= commit_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign load_en   = load_en_q;
  assign sort_en   = sort_en_q;
  assign commit_en = commit_en_q;
  assign done      = done_q;
  assign step_idx  = step_q;
  assign phase_idx = phase_q;
  assign step_odd  = step_q[0];
  assign phase_col = phase_q[0];

  ap_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({load_en, sort_en, commit_en, done}));

  ap_counters_idle: assert property (@(posedge clk) disable iff (rst)
    !sort_en |-> (step_idx == '0) && (phase_idx == '0));

  ap_geometry: assert property (@(posedge clk) disable iff (rst)
    (N == SQRT_N * SQRT_N) && (SQRT_N == (1 << LOG_SQRT_N)) && (SQRT_N >= 2));

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// Self-checking bench for mesh_sort_ctrl: pass-position model plus directed and random stimulus.
module tb_mesh_sort_ctrl;

  localparam int SQRT_N      = 8;
  localparam int LOG_SQRT_N  = 3;
  localparam int N           = 64;
  localparam int NUM_PHASES  = 2 * LOG_SQRT_N + 1;
  localparam int SORT_CYCLES = NUM_PHASES * SQRT_N;
  localparam int COMMIT_POS  = SORT_CYCLES + 1;
  localparam int DONE_POS    = SORT_CYCLES + 2;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic                  busy, load_en, sort_en, phase_col, step_odd, commit_en, done;
  logic [LOG_SQRT_N-1:0] step_idx;
  logic [LOG_SQRT_N:0]   phase_idx;

  int checks  = 0;
  int errors  = 0;
  bit checkOn = 1'b0;

  // Position within a pass: -1 idle, 0 load, 1..SORT_CYCLES sort, then commit, then done.
  int pos = -1;

  mesh_sort_ctrl #(
    .N(N), .SQRT_N(SQRT_N), .LOG_SQRT_N(LOG_SQRT_N)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .load_en(load_en), .sort_en(sort_en),
    .phase_col(phase_col), .step_odd(step_odd),
    .step_idx(step_idx), .phase_idx(phase_idx),
    .commit_en(commit_en), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a pass is just a position that advances one per cycle.
  always @(posedge clk or posedge rst) begin
    if (rst)                  pos <= -1;
    else if (pos < 0)         pos <= start ? 0 : -1;
    else if (abort)           pos <= -1;
    else if (pos == DONE_POS) pos <= -1;
    else                      pos <= pos + 1;
  end

  task automatic compareVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the pass position by plain arithmetic.
  task automatic checkOutput();
    bit inSort;
    int k, ph, st;
    inSort = (pos >= 1) && (pos <= SORT_CYCLES);
    k  = inSort ? pos - 1 : 0;
    ph = k / SQRT_N;
    st = k % SQRT_N;
    compareVal("busy",      int'(busy),      int'(pos >= 0));
    compareVal("load_en",   int'(load_en),   int'(pos == 0));
    compareVal("sort_en",   int'(sort_en),   int'(inSort));
    compareVal("commit_en", int'(commit_en), int'(pos == COMMIT_POS));
    compareVal("done",      int'(done),      int'(pos == DONE_POS));
    compareVal("phase_idx", int'(phase_idx), ph);
    compareVal("step_idx",  int'(step_idx),  st);
    compareVal("step_odd",  int'(step_odd),  st % 2);
    compareVal("phase_col", int'(phase_col), ph % 2);
  endtask

  always @(negedge clk) begin
    if (checkOn) checkOutput();
  end

  // Drive inputs, then wait the given number of edges and settle just after the last one.
  task automatic applyStimulus(input bit s, input bit a, input int cycles);
    start = s;
    abort = a;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  // One-cycle start pulse; returns 2 time units into cycle 1 of the new pass.
  task automatic startPulse();
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic countPass(input int maxCyc, input bit spots,
                           output int nLoad, output int nSort, output int nCommit,
                           output int nDone, output int doneCyc);
    nLoad = 0; nSort = 0; nCommit = 0; nDone = 0; doneCyc = -1;
    for (int cyc = 1; cyc <= maxCyc; cyc++) begin
      @(negedge clk);
      nLoad   += int'(load_en);
      nSort   += int'(sort_en);
      nCommit += int'(commit_en);
      nDone   += int'(done);
      if (done && doneCyc < 0) doneCyc = cyc;
      if (spots) begin
        case (cyc)
          1:  compareVal("c1_load", int'(load_en), 1);
          2:  begin
                compareVal("c2_sort",  int'(sort_en),   1);
                compareVal("c2_phase", int'(phase_idx), 0);
                compareVal("c2_step",  int'(step_idx),  0);
              end
          3:  begin
                compareVal("c3_step", int'(step_idx), 1);
                compareVal("c3_odd",  int'(step_odd), 1);
              end
          10: begin
                compareVal("c10_phase", int'(phase_idx), 1);
                compareVal("c10_step",  int'(step_idx),  0);
                compareVal("c10_col",   int'(phase_col), 1);
                compareVal("c10_odd",   int'(step_odd),  0);
              end
          57: begin
                compareVal("c57_phase", int'(phase_idx), 6);
                compareVal("c57_step",  int'(step_idx),  7);
                compareVal("c57_odd",   int'(step_odd),  1);
                compareVal("c57_col",   int'(phase_col), 0);
              end
          58: compareVal("c58_commit", int'(commit_en), 1);
          59: compareVal("c59_done",   int'(done),      1);
          60: compareVal("c60_busy",   int'(busy),      0);
          default: ;
        endcase
      end
    end
  endtask

  int  nLoad, nSort, nCommit, nDone, doneCyc;
  bit  found;
  int  abortRate;

  initial begin
    #1 rst = 1'b1;
    checkOn = 1'b1;
    applyStimulus(0, 0, 2);
    compareVal("reset_busy", int'(busy), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 10);
    compareVal("idle_busy", int'(busy), 0);

    // Full single pass with literal timing pins.
    startPulse();
    countPass(62, 1'b1, nLoad, nSort, nCommit, nDone, doneCyc);
    compareVal("pass1_loads",   nLoad,   1);
    compareVal("pass1_sorts",   nSort,   56);
    compareVal("pass1_commits", nCommit, 1);
    compareVal("pass1_dones",   nDone,   1);
    compareVal("pass1_done_cycle", doneCyc, 59);

    // Back-to-back passes with start held high.
    @(posedge clk); #2;
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    compareVal("b2b_done_seen", int'(found), 1);
    @(negedge clk);
    compareVal("b2b_gap_load", int'(load_en), 0);
    compareVal("b2b_gap_busy", int'(busy), 0);
    @(negedge clk);
    compareVal("b2b_reload", int'(load_en), 1);
    @(posedge clk); #2;
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 2);

    // Abort mid-sort, then a clean pass.
    startPulse();
    repeat (19) @(posedge clk);
    #2;
    applyStimulus(0, 1, 1);
    abort = 1'b0;
    @(negedge clk);
    compareVal("abort_busy", int'(busy), 0);
    compareVal("abort_sort", int'(sort_en), 0);
    countPass(70, 1'b0, nLoad, nSort, nCommit, nDone, doneCyc);
    compareVal("abort_no_done", nDone, 0);
    startPulse();
    countPass(62, 1'b0, nLoad, nSort, nCommit, nDone, doneCyc);
    compareVal("after_abort_sorts", nSort, 56);
    compareVal("after_abort_done_cycle", doneCyc, 59);

    // Asynchronous reset during the commit cycle.
    startPulse();
    repeat (57) @(posedge clk);
    #2;
    compareVal("commit_before_rst", int'(commit_en), 1);
    #1 rst = 1'b1;
    #1;
    compareVal("rst_commit_drop", int'(commit_en), 0);
    compareVal("rst_busy_drop", int'(busy), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    applyStimulus(0, 0, 2);
    startPulse();
    countPass(62, 1'b0, nLoad, nSort, nCommit, nDone, doneCyc);
    compareVal("after_rst_sorts", nSort, 56);
    compareVal("after_rst_done_cycle", doneCyc, 59);

    // Randomised stimulus against the model, with varying abort pressure and rare resets.
    for (int blk = 0; blk < 15; blk++) begin
      case ($urandom_range(0, 2))
        0:       abortRate = 0;
        1:       abortRate = 2;
        default: abortRate = 10;
      endcase
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 999) < 3);
        applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < abortRate, 1);
      end
    end
    rst = 1'b0;
    applyStimulus(0, 0, 3);

    checkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
